// File: rtl/unidade_acesso_memoria.sv
// Memory-access unit: converts byte-addressed byte/half/word loads and stores into
// word accesses on a word-addressed data memory, using read-modify-write for sub-word stores.
module unidade_acesso_memoria #(
  parameter int RAM_SIZE = 150
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_datain,
  input  logic [31:0] mem_dataout
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      r_state, w_next;
  logic        r_we, r_sign, r_done, r_err;
  logic [1:0]  r_size, r_off;
  logic [31:0] r_addr, r_wreg, r_rdata;

  logic [31:0] w_word;
  logic        w_bad, w_accept;
  logic [31:0] w_load, w_merge;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_word   = {2'b00, addr[31:2]};
  assign w_bad    = (size == SZ_ILL)
                 || (size == SZ_HALF && addr[0])
                 || (size == SZ_WORD && addr[1:0] != 2'b00)
                 || (w_word >= 32'(RAM_SIZE));
  assign w_accept = (r_state == S_IDLE) && req && !w_bad;

  assign busy       = (r_state != S_IDLE);
  assign mem_we     = (r_state == S_WR);
  assign mem_addr   = r_addr;
  assign mem_datain = r_wreg;
  assign rdata      = r_rdata;
  assign done       = r_done;
  assign err        = r_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (we && size == SZ_WORD) ? S_WR : S_RD;
      S_RD:   w_next = r_we ? S_WR : S_IDLE;
      S_WR:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Big-endian lane selection: offset 0 is the most significant byte.
  always_comb begin
    w_byte  = mem_dataout[7:0];
    w_half  = r_off[1] ? mem_dataout[15:0] : mem_dataout[31:16];
    w_load  = mem_dataout;
    w_merge = mem_dataout;
    case (r_off)
      2'd0: begin w_byte = mem_dataout[31:24]; w_merge[31:24] = r_wreg[7:0]; end
      2'd1: begin w_byte = mem_dataout[23:16]; w_merge[23:16] = r_wreg[7:0]; end
      2'd2: begin w_byte = mem_dataout[15:8];  w_merge[15:8]  = r_wreg[7:0]; end
      default: begin w_byte = mem_dataout[7:0]; w_merge[7:0] = r_wreg[7:0]; end
    endcase
    if (r_size == SZ_HALF) begin
      w_merge = mem_dataout;
      if (r_off[1]) w_merge[15:0]  = r_wreg[15:0];
      else          w_merge[31:16] = r_wreg[15:0];
      w_load = {{16{r_sign & w_half[15]}}, w_half};
    end else if (r_size == SZ_BYTE) begin
      w_load = {{24{r_sign & w_byte[7]}}, w_byte};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_sign  <= 1'b0;
      r_size  <= SZ_BYTE;
      r_off   <= 2'b00;
      r_addr  <= '0;
      r_wreg  <= '0;
      r_rdata <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req && w_bad) begin
            r_done <= 1'b1;
            r_err  <= 1'b1;
          end else if (req) begin
            r_err  <= 1'b0;
            r_we   <= we;
            r_size <= size;
            r_sign <= sign_ext;
            r_off  <= addr[1:0];
            r_addr <= w_word;
            r_wreg <= wdata;
          end
        end
        S_RD: begin
          if (r_we) r_wreg <= w_merge;
          else begin
            r_rdata <= w_load;
            r_done  <= 1'b1;
          end
        end
        S_WR: r_done <= 1'b1;
        default: r_done <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_acesso_memoria.sv
// Self-checking bench for unidade_acesso_memoria: directed vector table plus
// hand-written sequences for ignored requests and reset during a write.
module tb_unidade_acesso_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic [31:0] rdata, mem_addr, mem_datain, mem_dataout;
  logic        busy, done, err, mem_we;

  logic [31:0] mem [0:149];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  unidade_acesso_memoria #(.RAM_SIZE(150)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .rdata(rdata), .busy(busy), .done(done), .err(err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  // Word-addressed data memory: asynchronous read, write on posedge.
  assign mem_dataout = (mem_addr < 32'd150) ? mem[mem_addr] : 32'h0;
  always @(posedge clk) if (mem_we && mem_addr < 32'd150) mem[mem_addr] <= mem_datain;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    int          wecnt;
    int          midx;
    logic [31:0] mval;
  } vec_t;

  // Issues one request in the current (done) cycle and waits for its completion.
  task automatic do_op(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic e, output logic [31:0] rd, output int wecnt);
    @(negedge clk);
    req = 1'b1; we = w; size = sz; sign_ext = sg; addr = a; wdata = d;
    @(posedge clk); #1;
    req = 1'b0;
    lat = -1; wecnt = 0; e = 1'bx; rd = 'x;
    for (int c = 1; c <= 8; c++) begin
      if (mem_we) wecnt++;
      if (done) begin lat = c; e = err; rd = rdata; break; end
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs [22];

  initial begin
    int lat, wecnt, ndone;
    logic e;
    logic [31:0] rd;

    vecs[0]  = '{1, 2'b10, 0, 32'h4,   32'h11223344, 2, 0, 32'h00000000, 1, 1,   32'h11223344};
    vecs[1]  = '{0, 2'b10, 0, 32'h4,   32'h0,        2, 0, 32'h11223344, 0, 1,   32'h11223344};
    vecs[2]  = '{1, 2'b00, 0, 32'h5,   32'h000000AB, 3, 0, 32'h11223344, 1, 1,   32'h11AB3344};
    vecs[3]  = '{0, 2'b00, 1, 32'h5,   32'h0,        2, 0, 32'hFFFFFFAB, 0, 1,   32'h11AB3344};
    vecs[4]  = '{0, 2'b00, 0, 32'h5,   32'h0,        2, 0, 32'h000000AB, 0, 1,   32'h11AB3344};
    vecs[5]  = '{1, 2'b01, 0, 32'h6,   32'h0000BEEF, 3, 0, 32'h000000AB, 1, 1,   32'h11ABBEEF};
    vecs[6]  = '{0, 2'b01, 1, 32'h6,   32'h0,        2, 0, 32'hFFFFBEEF, 0, 1,   32'h11ABBEEF};
    vecs[7]  = '{0, 2'b10, 0, 32'h2,   32'h0,        1, 1, 32'hFFFFBEEF, 0, 1,   32'h11ABBEEF};
    vecs[8]  = '{1, 2'b01, 0, 32'h7,   32'h00001234, 1, 1, 32'hFFFFBEEF, 0, 1,   32'h11ABBEEF};
    vecs[9]  = '{1, 2'b11, 0, 32'h4,   32'h99999999, 1, 1, 32'hFFFFBEEF, 0, 1,   32'h11ABBEEF};
    vecs[10] = '{0, 2'b10, 0, 32'd600, 32'h0,        1, 1, 32'hFFFFBEEF, 0, 1,   32'h11ABBEEF};
    vecs[11] = '{1, 2'b10, 0, 32'd596, 32'hCAFEF00D, 2, 0, 32'hFFFFBEEF, 1, 149, 32'hCAFEF00D};
    vecs[12] = '{0, 2'b10, 0, 32'd596, 32'h0,        2, 0, 32'hCAFEF00D, 0, 149, 32'hCAFEF00D};
    vecs[13] = '{1, 2'b10, 0, 32'h8,   32'h80FF7F01, 2, 0, 32'hCAFEF00D, 1, 2,   32'h80FF7F01};
    vecs[14] = '{0, 2'b00, 1, 32'h8,   32'h0,        2, 0, 32'hFFFFFF80, 0, 2,   32'h80FF7F01};
    vecs[15] = '{0, 2'b00, 1, 32'hB,   32'h0,        2, 0, 32'h00000001, 0, 2,   32'h80FF7F01};
    vecs[16] = '{0, 2'b01, 1, 32'hA,   32'h0,        2, 0, 32'h00007F01, 0, 2,   32'h80FF7F01};
    vecs[17] = '{0, 2'b01, 0, 32'h8,   32'h0,        2, 0, 32'h000080FF, 0, 2,   32'h80FF7F01};
    vecs[18] = '{1, 2'b00, 0, 32'hB,   32'hFFFFFF12, 3, 0, 32'h000080FF, 1, 2,   32'h80FF7F12};
    vecs[19] = '{0, 2'b10, 0, 32'h8,   32'h0,        2, 0, 32'h80FF7F12, 0, 2,   32'h80FF7F12};
    vecs[20] = '{1, 2'b10, 0, 32'd600, 32'h55555555, 1, 1, 32'h80FF7F12, 0, 149, 32'hCAFEF00D};
    vecs[21] = '{1, 2'b01, 0, 32'h2,   32'h0000A5C3, 3, 0, 32'h80FF7F12, 1, 0,   32'h0000A5C3};

    for (int i = 0; i < 150; i++) mem[i] = 32'h0;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign_ext = 1'b0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset done", {31'b0, done}, 32'h0);
    check("reset mem_we", {31'b0, mem_we}, 32'h0);
    check("reset rdata", rdata, 32'h0);
    @(negedge clk); reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      do_op(vecs[i].we, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata, lat, e, rd, wecnt);
      check($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("v%0d err", i), {31'b0, e}, {31'b0, vecs[i].err});
      check($sformatf("v%0d rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d mem_we cycles", i), 32'(wecnt), 32'(vecs[i].wecnt));
      check($sformatf("v%0d mem word", i), mem[vecs[i].midx], vecs[i].mval);
    end

    // A store request presented while a load is in flight must be dropped.
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; sign_ext = 1'b0; addr = 32'h4;
    @(posedge clk); #1;
    check("ign busy after accept", {31'b0, busy}, 32'h1);
    @(negedge clk);
    we = 1'b1; addr = 32'h10; wdata = 32'hDEADBEEF;
    @(posedge clk); #1;
    req = 1'b0;
    check("ign load done", {31'b0, done}, 32'h1);
    check("ign load rdata", rdata, 32'h11ABBEEF);
    ndone = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done || mem_we) ndone++;
    end
    check("ign no extra activity", 32'(ndone), 32'h0);
    check("ign mem untouched", mem[4], 32'h0);

    // Reset during WR of a byte store: write enable drops at once, memory intact.
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h10; wdata = 32'h00000055;
    @(posedge clk); #1;
    req = 1'b0;
    @(posedge clk); #1;
    check("rst pre mem_we", {31'b0, mem_we}, 32'h1);
    reset = 1'b1;
    #1;
    check("rst mem_we drop", {31'b0, mem_we}, 32'h0);
    check("rst busy", {31'b0, busy}, 32'h0);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst mem_datain", mem_datain, 32'h0);
    check("rst rdata", rdata, 32'h0);
    @(posedge clk); #1;
    check("rst mem unchanged", mem[4], 32'h0);
    check("rst done", {31'b0, done}, 32'h0);
    check("rst err", {31'b0, err}, 32'h0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("post rst busy", {31'b0, busy}, 32'h0);
    check("post rst mem unchanged", mem[4], 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
